// File: rtl/mc_cpu_pkg.sv
// mc_cpu_pkg: shared definitions for the multi-cycle MIPS-subset core.
//   - FSM state encoding
//   - opcode / funct constants for the supported subset
//   - ALU operation codes and the funct -> ALU op mapping
//   - reset defaults and small decode helpers
package mc_cpu_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  localparam logic [31:0] WORD_RST = 32'h0000_0000;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic alu_op_t funct_to_alu(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
    case (op)
      OP_RTYPE: return funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: 32 x 32-bit register file, two asynchronous read ports and
// one synchronous write port. Register 0 always reads as zero and writes
// to it are dropped. All registers clear on asynchronous reset.
//   clkin              clock, rising edge
//   reset              asynchronous, active-high
//   we/waddr/wdata     write port
//   raddr_a/rdata_a    read port A
//   raddr_b/rdata_b    read port B
module mc_regfile
  import mc_cpu_pkg::*;
(
  input  logic        clkin,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  output logic [31:0] rdata_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_b
);

  logic [31:0] regs [32];

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= WORD_RST;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? WORD_RST : regs[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? WORD_RST : regs[raddr_b];

endmodule

// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multi-cycle MIPS-subset core (add/sub/and/or/slt, addi, lw,
// sw, beq, j) behind one unified memory port with a req/ready handshake.
//   clkin      clock, rising edge
//   reset      asynchronous, active-high
//   mem_req    memory transfer request (FETCH or MEM state)
//   mem_we     1 = store (sw), 0 = read
//   mem_addr   byte address (pc in FETCH, ALUOut in MEM)
//   mem_wdata  store data (B register)
//   mem_ready  transfer completes on an edge where mem_req & mem_ready
//   mem_rdata  read data, valid with mem_ready
//   pc_out     PC of the instruction currently executing
//   retire     one-cycle pulse per completed instruction
//   halted     core is in HALT
module mc_cpu_core
  import mc_cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W          = 32,
  parameter logic [ADDR_W-1:0] RESET_PC        = '0,
  parameter bit                TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic              clkin,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] pc_out,
  output logic              retire,
  output logic              halted
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] cur_pc;
  logic [31:0]       ir, a_reg, b_reg, alu_out, mdr;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] tgt;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign imm   = ir[15:0];
  assign funct = ir[5:0];
  assign tgt   = ir[25:0];

  logic [31:0]       imm_ext, pc_ext, rs_data, rt_data, alu_b, alu_y;
  logic [ADDR_W-1:0] jump_target;
  logic              legal;
  alu_op_t           alu_op;

  assign imm_ext = sext16(imm);
  assign pc_ext  = 32'(pc);
  assign legal   = is_legal(op, funct);
  // pc already holds pc+4 by DECODE, so the jump takes its upper nibble from there.
  assign jump_target = ADDR_W'({pc_ext[31:28], tgt, 2'b00});

  // Register file write happens on the WB edge only.
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign rf_we    = (state == ST_WB);
  assign rf_waddr = (op == OP_RTYPE) ? rd : rt;
  assign rf_wdata = (op == OP_LW) ? mdr : alu_out;

  mc_regfile u_regfile (
    .clkin   (clkin),
    .reset   (reset),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (rs),
    .rdata_a (rs_data),
    .raddr_b (rt),
    .rdata_b (rt_data)
  );

  assign alu_op = (op == OP_RTYPE) ? funct_to_alu(funct) : ALU_ADD;
  assign alu_b  = (op == OP_RTYPE) ? b_reg : imm_ext;

  always_comb begin
    alu_y = a_reg + alu_b;
    case (alu_op)
      ALU_SUB: alu_y = a_reg - alu_b;
      ALU_AND: alu_y = a_reg & alu_b;
      ALU_OR:  alu_y = a_reg | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(a_reg) < $signed(alu_b)};
      default: ;
    endcase
  end

  // Memory port is decoded from state so that an async reset drops mem_req at once.
  assign mem_req   = (state == ST_FETCH) || (state == ST_MEM);
  assign mem_we    = (state == ST_MEM) && (op == OP_SW);
  assign mem_wdata = (state == ST_MEM) ? b_reg : WORD_RST;

  always_comb begin
    mem_addr = '0;
    case (state)
      ST_FETCH: mem_addr = pc;
      ST_MEM:   mem_addr = ADDR_W'(alu_out);
      default:  ;
    endcase
  end

  assign pc_out = cur_pc;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state   <= ST_BOOT;
      pc      <= RESET_PC;
      cur_pc  <= RESET_PC;
      ir      <= WORD_RST;
      a_reg   <= WORD_RST;
      b_reg   <= WORD_RST;
      alu_out <= WORD_RST;
      mdr     <= WORD_RST;
      retire  <= 1'b0;
      halted  <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        ST_BOOT: state <= ST_FETCH;
        ST_FETCH: begin
          if (mem_ready) begin
            ir     <= mem_rdata;
            cur_pc <= pc;
            pc     <= pc + ADDR_W'(32'd4);
            state  <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          a_reg   <= rs_data;
          b_reg   <= rt_data;
          alu_out <= pc_ext + {imm_ext[29:0], 2'b00};
          if (!legal) begin
            if (TRAP_ON_ILLEGAL) begin
              halted <= 1'b1;
              state  <= ST_HALT;
            end else begin
              retire <= 1'b1;
              state  <= ST_FETCH;
            end
          end else if (op == OP_J) begin
            pc     <= jump_target;
            retire <= 1'b1;
            state  <= ST_FETCH;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (op == OP_BEQ) begin
            if (a_reg == b_reg) pc <= ADDR_W'(alu_out);
            retire <= 1'b1;
            state  <= ST_FETCH;
          end else begin
            alu_out <= alu_y;
            state   <= ((op == OP_LW) || (op == OP_SW)) ? ST_MEM : ST_WB;
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            if (op == OP_SW) begin
              retire <= 1'b1;
              state  <= ST_FETCH;
            end else begin
              mdr   <= mem_rdata;
              state <= ST_WB;
            end
          end
        end
        ST_WB: begin
          retire <= 1'b1;
          state  <= ST_FETCH;
        end
        ST_HALT: halted <= 1'b1;
        default: begin
          halted <= 1'b1;
          state  <= ST_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_cpu_core.sv
// Directed testbench for mc_cpu_core. A second instance with illegal
// opcodes executing as NOPs shares the program memory (read-only, always ready).
module tb_mc_cpu_core;

  localparam logic [5:0] OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SLT = 6'h2a;
  localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

  logic        clkin = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;

  logic        nt_req, nt_we, nt_retire, nt_halted;
  logic [31:0] nt_addr, nt_wdata, nt_rdata, nt_pc;

  logic [31:0] mem [0:255];
  int          wait_n = 0;
  int          cnt;
  logic [31:0] fetch_q [$];

  int checks = 0;
  int errors = 0;

  always #5 clkin = ~clkin;

  mc_cpu_core #(.ADDR_W(32), .RESET_PC(32'h100), .TRAP_ON_ILLEGAL(1'b1)) dut (
    .clkin(clkin), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .pc_out(pc_out),
    .retire(retire), .halted(halted)
  );

  mc_cpu_core #(.ADDR_W(32), .RESET_PC(32'h100), .TRAP_ON_ILLEGAL(1'b0)) dut_nt (
    .clkin(clkin), .reset(reset), .mem_req(nt_req), .mem_we(nt_we), .mem_addr(nt_addr),
    .mem_wdata(nt_wdata), .mem_ready(nt_req), .mem_rdata(nt_rdata), .pc_out(nt_pc),
    .retire(nt_retire), .halted(nt_halted)
  );

  assign mem_ready = mem_req && (cnt >= wait_n);
  assign mem_rdata = mem[mem_addr[9:2]];
  assign nt_rdata  = mem[nt_addr[9:2]];

  always @(posedge clkin or posedge reset) begin
    if (reset) begin
      cnt <= 0;
    end else if (mem_req && mem_ready) begin
      cnt <= 0;
      if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
      else fetch_q.push_back(mem_addr);
    end else if (mem_req) begin
      cnt <= cnt + 1;
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] tgt);
    return {OP_J, tgt};
  endfunction

  task automatic hold_reset();
    reset = 1'b1;
    wait_n = 0;
    @(negedge clkin);
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    fetch_q.delete();
  endtask

  task automatic release_reset();
    @(negedge clkin);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    hold_reset();
    mem[64] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd1);
    #1;
    checks++;
    if ({mem_req, mem_we, retire, halted} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctl: req/we/retire/halted=%b required 0000",
               {mem_req, mem_we, retire, halted});
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h wdata=%h required 0/0", mem_addr, mem_wdata);
    end
    checks++;
    if (pc_out !== 32'h100) begin
      errors++;
      $display("FAIL reset_pc: pc_out=%h required 00000100", pc_out);
    end
    release_reset();
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL boot_req: mem_req=%b required 0 in BOOT", mem_req);
    end
    @(negedge clkin);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL first_fetch: req=%b addr=%h we=%b required 1/00000100/0",
               mem_req, mem_addr, mem_we);
    end
  endtask

  task automatic test_alu();
    int rcnt = 0;
    int last = 0;
    hold_reset();
    mem[64] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
    mem[65] = enc_i(OP_ADDI, 5'd0, 5'd2, 16'hFFFD);
    mem[66] = enc_r(5'd1, 5'd2, 5'd3, FN_ADD);
    mem[67] = enc_r(5'd2, 5'd1, 5'd4, FN_SLT);
    mem[68] = ILLEGAL;
    release_reset();
    for (int n = 1; n <= 17; n++) begin
      @(negedge clkin);
      if (retire) begin
        rcnt++;
        last = n;
      end
    end
    checks++;
    if (rcnt != 4 || last != 17) begin
      errors++;
      $display("FAIL alu_timing: retires=%0d last_cycle=%0d required 4/17", rcnt, last);
    end
    checks++;
    if (dut.u_regfile.regs[1] !== 32'd5 || dut.u_regfile.regs[2] !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL addi_vals: r1=%h r2=%h required 00000005/fffffffd",
               dut.u_regfile.regs[1], dut.u_regfile.regs[2]);
    end
    checks++;
    if (dut.u_regfile.regs[3] !== 32'd2) begin
      errors++;
      $display("FAIL add_wrap: r3=%h required 00000002", dut.u_regfile.regs[3]);
    end
    checks++;
    if (dut.u_regfile.regs[4] !== 32'd1) begin
      errors++;
      $display("FAIL slt_signed: r4=%h required 00000001", dut.u_regfile.regs[4]);
    end
  endtask

  task automatic wait_data_addr(input string name, output logic found);
    found = 1'b0;
    for (int n = 0; n < 80 && !found; n++) begin
      @(negedge clkin);
      if (mem_req && mem_addr == 32'h8) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: data access at 00000008 seen=0 required 1 within 80 cycles", name);
    end
  endtask

  task automatic test_mem_wait();
    logic found;
    hold_reset();
    mem[64] = enc_i(OP_ADDI, 5'd0, 5'd3, 16'd2);
    mem[65] = enc_i(OP_SW, 5'd0, 5'd3, 16'd8);
    mem[66] = enc_i(OP_LW, 5'd0, 5'd5, 16'd8);
    mem[67] = ILLEGAL;
    wait_n = 3;
    release_reset();
    wait_data_addr("sw_reach", found);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({mem_we, mem_ready} !== 2'b10 || mem_addr !== 32'h8 || mem_wdata !== 32'd2) begin
        errors++;
        $display("FAIL sw_wait%0d: we=%b rdy=%b addr=%h wdata=%h required 1/0/00000008/00000002",
                 k, mem_we, mem_ready, mem_addr, mem_wdata);
      end
      @(negedge clkin);
    end
    checks++;
    if ({mem_we, mem_ready} !== 2'b11 || mem_addr !== 32'h8) begin
      errors++;
      $display("FAIL sw_ack: we=%b rdy=%b addr=%h required 1/1/00000008",
               mem_we, mem_ready, mem_addr);
    end
    @(negedge clkin);
    checks++;
    if (mem[2] !== 32'd2) begin
      errors++;
      $display("FAIL sw_data: mem[8]=%h required 00000002", mem[2]);
    end
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h108) begin
      errors++;
      $display("FAIL sw_to_fetch: req=%b addr=%h required 1/00000108", mem_req, mem_addr);
    end
    wait_data_addr("lw_reach", found);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem_we !== 1'b0 || mem_addr !== 32'h8 || mem_ready !== (k == 3)) begin
        errors++;
        $display("FAIL lw_wait%0d: we=%b addr=%h rdy=%b required 0/00000008/%0d",
                 k, mem_we, mem_addr, mem_ready, (k == 3));
      end
      @(negedge clkin);
    end
    repeat (4) @(negedge clkin);
    checks++;
    if (dut.u_regfile.regs[5] !== 32'd2) begin
      errors++;
      $display("FAIL lw_data: r5=%h required 00000002", dut.u_regfile.regs[5]);
    end
    wait_n = 0;
  endtask

  task automatic test_branch_loop();
    int rc[$];
    hold_reset();
    mem[64] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd1);
    mem[65] = enc_i(OP_BEQ, 5'd1, 5'd1, 16'hFFFF);
    release_reset();
    for (int n = 1; n <= 16; n++) begin
      @(negedge clkin);
      if (retire) rc.push_back(n);
    end
    checks++;
    if (fetch_q.size() != 5 || fetch_q[0] !== 32'h100 || fetch_q[1] !== 32'h104 ||
        fetch_q[2] !== 32'h104 || fetch_q[3] !== 32'h104) begin
      errors++;
      $display("FAIL beq_taken: fetches=%0d seq=%h %h %h %h required 5 fetches 100 104 104 104",
               fetch_q.size(), fetch_q[0], fetch_q[1], fetch_q[2], fetch_q[3]);
    end
    checks++;
    if (rc.size() != 4 || rc[1] != 8 || rc[2] != 11) begin
      errors++;
      $display("FAIL beq_latency: retires=%0d at %0d,%0d required 4 at 8,11",
               rc.size(), rc[1], rc[2]);
    end
    checks++;
    if (pc_out !== 32'h104) begin
      errors++;
      $display("FAIL beq_pc_out: pc_out=%h required 00000104", pc_out);
    end
  endtask

  task automatic test_branch_jump();
    hold_reset();
    mem[64] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd1);
    mem[65] = enc_i(OP_BEQ, 5'd1, 5'd0, 16'd5);
    mem[66] = enc_j(26'h40);
    release_reset();
    repeat (12) @(negedge clkin);
    checks++;
    if (fetch_q.size() != 4 || fetch_q[2] !== 32'h108 || fetch_q[3] !== 32'h100) begin
      errors++;
      $display("FAIL beq_nt_j: fetches=%0d third=%h fourth=%h required 4/00000108/00000100",
               fetch_q.size(), fetch_q[2], fetch_q[3]);
    end
    checks++;
    if (pc_out !== 32'h100) begin
      errors++;
      $display("FAIL j_pc_out: pc_out=%h required 00000100", pc_out);
    end
  endtask

  task automatic test_illegal();
    int bad = 0;
    int nt_rc = 0;
    int rc = 0;
    hold_reset();
    mem[64] = ILLEGAL;
    mem[65] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd7);
    mem[66] = enc_i(OP_BEQ, 5'd0, 5'd0, 16'hFFFF);
    release_reset();
    for (int n = 1; n <= 12; n++) begin
      @(negedge clkin);
      if (n >= 3 && (halted !== 1'b1 || mem_req !== 1'b0)) bad++;
      if (retire) rc++;
      if (nt_retire) nt_rc++;
    end
    checks++;
    if (bad != 0 || rc != 0) begin
      errors++;
      $display("FAIL trap_halt: bad_cycles=%0d retires=%0d halted=%b required 0/0/1",
               bad, rc, halted);
    end
    checks++;
    if (nt_rc != 3 || nt_halted !== 1'b0) begin
      errors++;
      $display("FAIL nop_retire: retires=%0d halted=%b required 3/0", nt_rc, nt_halted);
    end
    checks++;
    if (dut_nt.u_regfile.regs[1] !== 32'd7 || nt_pc !== 32'h108) begin
      errors++;
      $display("FAIL nop_continue: r1=%h pc_out=%h required 00000007/00000108",
               dut_nt.u_regfile.regs[1], nt_pc);
    end
  endtask

  task automatic test_reset_mid();
    hold_reset();
    mem[64] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd9);
    mem[65] = enc_i(OP_ADDI, 5'd0, 5'd2, 16'd1);
    release_reset();
    repeat (5) @(negedge clkin);
    checks++;
    if (dut.u_regfile.regs[1] !== 32'd9) begin
      errors++;
      $display("FAIL pre_reset_r1: r1=%h required 00000009", dut.u_regfile.regs[1]);
    end
    wait_n = 5;
    @(negedge clkin);
    checks++;
    if (mem_req !== 1'b1 || mem_ready !== 1'b0 || mem_addr !== 32'h104) begin
      errors++;
      $display("FAIL fetch_wait: req=%b rdy=%b addr=%h required 1/0/00000104",
               mem_req, mem_ready, mem_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || retire !== 1'b0) begin
      errors++;
      $display("FAIL async_abort: req=%b addr=%h retire=%b required 0/0/0",
               mem_req, mem_addr, retire);
    end
    checks++;
    if (dut.u_regfile.regs[1] !== 32'h0 || pc_out !== 32'h100) begin
      errors++;
      $display("FAIL reset_state: r1=%h pc_out=%h required 0/00000100",
               dut.u_regfile.regs[1], pc_out);
    end
    wait_n = 0;
    @(negedge clkin);
    reset = 1'b0;
    @(negedge clkin);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL restart: req=%b addr=%h required 1/00000100", mem_req, mem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem_wait();
    test_branch_loop();
    test_branch_jump();
    test_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
